// File: rtl/des_key_schedule.sv
// DES round-subkey generator: PC-1 on start, then one PC-2 subkey per valid/ready transfer (K1..K16 or K16..K1).
// First subkey is valid the cycle after start; a stalled consumer freezes subkey/round/{C,D} indefinitely.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        done
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // FIPS 46-3 tables, bit 1 = MSB; first 28 PC-1 entries form C, the rest D.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_step;
  logic        r_dec;
  logic        r_done;

  logic [27:0] w_pc1_c;
  logic [27:0] w_pc1_d;
  logic [55:0] w_cd;
  logic [47:0] w_pc2;
  logic [3:0]  w_next_step;
  logic [1:0]  w_amt;
  logic        w_emit;
  logic        w_unused_parity;

  for (genvar i = 0; i < 28; i++) begin : g_pc1
    assign w_pc1_c[27-i] = key[64-PC1[i]];
    assign w_pc1_d[27-i] = key[64-PC1[28+i]];
  end

  assign w_cd = {r_c, r_d};

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign w_pc2[47-i] = w_cd[56-PC2[i]];
  end

  assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

  // Decrypt walks the encrypt schedule backwards, so step 0 needs no rotation at all.
  function automatic logic [1:0] shift_amt(input logic [3:0] s, input logic dec);
    if (s == 4'd0)
      return dec ? 2'd0 : 2'd1;
    if (s == 4'd1 || s == 4'd8 || s == 4'd15)
      return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] v, input logic [1:0] n, input logic dec);
    logic [27:0] r;
    r = v;
    if (n == 2'd1)
      r = dec ? {v[0], v[27:1]} : {v[26:0], v[27]};
    else if (n == 2'd2)
      r = dec ? {v[1:0], v[27:2]} : {v[25:0], v[27:26]};
    return r;
  endfunction

  assign w_next_step = r_step + 4'd1;
  assign w_amt       = shift_amt(w_next_step, r_dec);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_step  <= '0;
      r_dec   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dec   <= decrypt;
            r_c     <= rot(w_pc1_c, shift_amt(4'd0, decrypt), decrypt);
            r_d     <= rot(w_pc1_d, shift_amt(4'd0, decrypt), decrypt);
            r_step  <= '0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (subkey_ready) begin
            if (r_step == 4'd15) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_step  <= '0;
            end else begin
              r_c    <= rot(r_c, w_amt, r_dec);
              r_d    <= rot(r_d, w_amt, r_dec);
              r_step <= w_next_step;
            end
          end
        end
      endcase
    end
  end

  assign w_emit       = (r_state == S_EMIT);
  assign busy         = w_emit;
  assign subkey_valid = w_emit;
  assign subkey       = w_emit ? w_pc2 : '0;
  assign round        = w_emit ? r_step : '0;
  assign done         = r_done;

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES subkey generator; sits directly upstream of the DES round datapath.
- Captures one 64-bit key and applies PC-1.
- Emits the 16 48-bit round subkeys one per handshake: K1..K16 for encryption, K16..K1 for decryption.
- The round stage consumes each subkey via a valid/ready handshake, so it can stall the schedule.

Parameters:
- none (DES tables and round count are fixed by FIPS 46-3)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request new schedule; accepted only in IDLE
- key  input  64  DES key, bit 1 (FIPS numbering) = key[63]; parity bits 8,16,..,64 ignored
- decrypt  input  1  sampled with start: 0 = K1..K16 order, 1 = K16..K1 order
- busy  output  1  high while a schedule is in progress (state EMIT)
- subkey_valid  output  1  subkey is presented
- subkey_ready  input  1  consumer accepts subkey this cycle
- subkey  output  48  current round key, FIPS bit 1 = subkey[47]; forced 0 when subkey_valid=0
- round  output  4  step index 0..15 of the presented subkey (0 when idle)
- done  output  1  one-cycle pulse after the 16th subkey is transferred

Behaviour:
- Reset (rst=1 at an edge) from any state, including mid-schedule:
  - state -> IDLE; C, D, round -> 0
  - busy, subkey_valid, done -> 0; subkey -> 0
  - in-flight schedule abandoned, no done pulse
- Registers: C[27:0] and D[27:0] = PC-1 halves, state {IDLE, EMIT}, 4-bit step counter, captured decrypt flag.
- Tables: standard FIPS 46-3 PC-1, PC-2 and shift schedule, bit 1 = MSB. subkey = PC-2({C,D}) combinationally from registers, pure wiring.
- Encrypt shift per step (left rotate, applied before emitting that step's key): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt shift per step (right rotate): 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Step 0 is unrotated PC-1, i.e. C16/D16 = K16.
- IDLE, start=1 at edge:
  - capture decrypt
  - load {C,D} = PC-1(key) with step-0 rotation applied (left 1 if encrypt, none if decrypt)
  - step <- 0; state -> EMIT
- Latency: subkey_valid rises in the cycle after start is accepted.
- EMIT:
  - subkey_valid=1, busy=1, round=step.
  - Transfer occurs at an edge with subkey_valid & subkey_ready.
  - subkey, round and {C,D} hold stable until transfer; stalls are unlimited.
  - Transfer with step<15: rotate {C,D} by the next step's amount in the captured direction; step+1.
  - Transfer with step==15: state -> IDLE; done=1 for exactly the following cycle; C/D hold, output gated.
- Gating and input sampling:
  - start while busy: ignored.
  - key/decrypt changes after acceptance: no effect.
- Back-to-back: start is accepted in the same cycle done is high (state is IDLE), giving one idle cycle between schedules.
- Rotation sanity: over 16 encrypt steps the total left rotation is 28, so C and D return to PC-1 values. Decrypt mirrors this.
- rst and start in the same cycle: rst wins, start dropped.

Test Plan:
- key=0x133457799BBCDFF1, decrypt=0, ready held 1 → subkey_valid high 16 consecutive cycles:
  - round0 = 0x1B02EFFC7072, round1 = 0x79AED9DBC9E5, round15 = 0xCB3D8B0E17F5
  - done pulses once on the cycle after round15 is transferred.
- Same key, decrypt=1 → round0 = 0xCB3D8B0E17F5, round14 = 0x79AED9DBC9E5, round15 = 0x1B02EFFC7072; sequence exactly reverses the encrypt run.
- Stall: same key, encrypt, deassert ready for 5 cycles at round 3 and randomly thereafter:
  - subkey/round hold during stalls
  - all 16 values match the unstalled run
  - done only after the 16th transfer.
- Parity/degenerate keys:
  - key=0x0101010101010101 → all 16 subkeys 0x000000000000
  - key=0xFEFEFEFEFEFEFEFE → all 16 subkeys 0xFFFFFFFFFFFF.
- Protocol: start pulsed while busy at round 7 with a different key → ignored, current sequence unchanged. New start in the done cycle → accepted, round0 of the new key valid next cycle.
- Reset mid-operation: rst=1 at round 9 → next cycle busy=0, subkey_valid=0, subkey=0, round=0, no done pulse. A fresh start then yields the correct round0.
